// File: rtl/menu_nav_ctrl_if.sv
// Key-event input and menu/pointer/selection outputs of the menu navigation controller.
// Latency: none (wires only).
// Backpressure: none; key events are one-cycle strobes and outputs are free-running.
interface menu_nav_ctrl_if #(
    parameter int PW = 2,
    parameter int IW = 2
);
    logic [3:0]    keyboard_in;
    logic [PW-1:0] menu_state;
    logic [IW-1:0] menu_counter;
    logic [10:0]   x_pointer;
    logic [10:0]   y_pointer;
    logic          pointer_visible;
    logic          select_valid;
    logic [PW-1:0] select_page;
    logic [IW-1:0] select_item;

    // Keyboard/game side: produces key events, consumes menu state.
    modport master (
        output keyboard_in,
        input  menu_state, menu_counter, x_pointer, y_pointer,
        input  pointer_visible, select_valid, select_page, select_item
    );

    // Controller side.
    modport slave (
        input  keyboard_in,
        output menu_state, menu_counter, x_pointer, y_pointer,
        output pointer_visible, select_valid, select_page, select_item
    );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Menu page/item navigation from key events, pointer coordinates, blink and idle timeout.
// Latency: page/item/select after the sampling edge; pointer y one edge later.
// Backpressure: none; every nonzero key code is consumed on the cycle it arrives.
module menu_nav_ctrl #(
    parameter int NUM_PAGES      = 3,
    parameter int NUM_ITEMS      = 3,
    parameter int WRAP           = 1,
    parameter int X_BASE         = 300,
    parameter int Y_BASE         = 200,
    parameter int Y_STEP         = 100,
    parameter int BLINK_CYCLES   = 32500000,
    parameter int TIMEOUT_CYCLES = 650000000
) (
    input  logic           clk,
    input  logic           rst,
    menu_nav_ctrl_if.slave bus
);
    localparam int PW = (NUM_PAGES > 2) ? $clog2(NUM_PAGES) : 1;
    localparam int IW = (NUM_ITEMS > 2) ? $clog2(NUM_ITEMS) : 1;
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam bit            TO_EN      = (TIMEOUT_CYCLES > 0);
    localparam logic [IW-1:0] ITEM_LAST  = IW'(NUM_ITEMS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [10:0]   X_B        = 11'(X_BASE);
    localparam logic [10:0]   Y_B        = 11'(Y_BASE);
    localparam logic [10:0]   Y_S        = 11'(Y_STEP);

    typedef enum logic [3:0] {
        KEY_NONE  = 4'd0,
        KEY_UP    = 4'd1,
        KEY_DOWN  = 4'd2,
        KEY_ENTER = 4'd3,
        KEY_ESC   = 4'd4
    } key_e;

    logic          is_up, is_down, is_enter, is_esc, nav_key, any_key, timeout_hit;

    logic [PW-1:0] page_q, page_d;
    logic [IW-1:0] item_q, item_d;
    logic          sel_vld_q, sel_vld_d;
    logic [PW-1:0] sel_page_q, sel_page_d;
    logic [IW-1:0] sel_item_q, sel_item_d;
    logic [10:0]   y_q;
    logic          vis_q;
    logic [BW-1:0] blink_q;
    logic [TW-1:0] idle_q;

    assign is_up    = (bus.keyboard_in == KEY_UP);
    assign is_down  = (bus.keyboard_in == KEY_DOWN);
    assign is_enter = (bus.keyboard_in == KEY_ENTER);
    assign is_esc   = (bus.keyboard_in == KEY_ESC);
    assign nav_key  = is_up | is_down | is_enter | is_esc;
    // Unknown codes still count as activity for the idle timer.
    assign any_key  = (bus.keyboard_in != KEY_NONE);
    // A key on the expiry cycle takes priority over the timeout.
    assign timeout_hit = TO_EN && !any_key && (idle_q == IDLE_LAST);

    // Page/item/selection state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_q     <= '0;
            item_q     <= '0;
            sel_vld_q  <= 1'b0;
            sel_page_q <= '0;
            sel_item_q <= '0;
        end else begin
            page_q     <= page_d;
            item_q     <= item_d;
            sel_vld_q  <= sel_vld_d;
            sel_page_q <= sel_page_d;
            sel_item_q <= sel_item_d;
        end
    end

    // Next page/item and selection strobe from the decoded key or the idle timeout.
    always_comb begin
        page_d     = page_q;
        item_d     = item_q;
        sel_vld_d  = 1'b0;
        sel_page_d = sel_page_q;
        sel_item_d = sel_item_q;
        if (is_up) begin
            if (item_q == '0) begin
                item_d = (WRAP != 0) ? ITEM_LAST : '0;
            end else begin
                item_d = item_q - IW'(1);
            end
        end else if (is_down) begin
            if (item_q >= ITEM_LAST) begin
                item_d = (WRAP != 0) ? '0 : ITEM_LAST;
            end else begin
                item_d = item_q + IW'(1);
            end
        end else if (is_enter) begin
            if (page_q == '0 && (int'(item_q) + 1 < NUM_PAGES)) begin
                // Main-page entries open sub-pages 1..NUM_PAGES-1.
                page_d = PW'(int'(item_q) + 1);
                item_d = '0;
            end else begin
                // Entries past the last sub-page, and any sub-page item, are final picks.
                sel_vld_d  = 1'b1;
                sel_page_d = page_q;
                sel_item_d = item_q;
            end
        end else if (is_esc) begin
            if (page_q != '0) begin
                // Land back on the main-page entry that opened this page.
                page_d = '0;
                item_d = IW'(int'(page_q) - 1);
            end
        end else if (timeout_hit) begin
            page_d = '0;
            item_d = '0;
        end
    end

    // Idle counter: cleared by any key, wraps to zero on expiry, parked at zero when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else if (any_key || timeout_hit) begin
            idle_q <= '0;
        end else if (TO_EN) begin
            idle_q <= idle_q + TW'(1);
        end
    end

    // Blink phase: toggles every BLINK_CYCLES, restarted visible on any navigation key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
            vis_q   <= 1'b1;
        end else if (nav_key) begin
            blink_q <= '0;
            vis_q   <= 1'b1;
        end else if (blink_q >= BLINK_LAST) begin
            blink_q <= '0;
            vis_q   <= ~vis_q;
        end else begin
            blink_q <= blink_q + BW'(1);
        end
    end

    // Pointer y follows the registered item one edge later; 11-bit wraparound is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= Y_B;
        end else begin
            y_q <= Y_B + (11'(item_q) * Y_S);
        end
    end

    assign bus.menu_state      = page_q;
    assign bus.menu_counter    = item_q;
    assign bus.x_pointer       = X_B;
    assign bus.y_pointer       = y_q;
    assign bus.pointer_visible = vis_q;
    assign bus.select_valid    = sel_vld_q;
    assign bus.select_page     = sel_page_q;
    assign bus.select_item     = sel_item_q;
endmodule

// File: doc/menu_nav_ctrl.md
Name: menu_nav_ctrl

Overview:
- Parametrised successor to the fixed menu page/counter logic.
- Converts one-cycle keyboard event codes into a menu page and item selection, with a configurable number of pages and items.
- Produces registered pointer coordinates for the pointer-drawing stage in the 65 MHz VGA pipeline, plus a blink-enable signal.
- Adds wrap/saturate mode, an idle timeout back to the main page, and a one-cycle selection strobe for game-state logic.

Parameters:
- NUM_PAGES, 3, number of menu pages (≥2); page 0 is the main page.
- NUM_ITEMS, 3, items per page (≥2).
- WRAP, 1, 1 = up/down wrap around at the ends; 0 = saturate at the ends.
- X_BASE, 300, pointer x on every page (11-bit).
- Y_BASE, 200, pointer y for item 0 (11-bit).
- Y_STEP, 100, vertical pitch between items (11-bit).
- BLINK_CYCLES, 32500000, half-period of the pointer blink, in clk cycles.
- TIMEOUT_CYCLES, 650000000, idle cycles before an automatic return to page 0, item 0; 0 disables the timeout.

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  asynchronous, active-high reset
- keyboard_in  in  4  one-cycle key event code (rising-edge output of the keyboard path); 0 = no event
- menu_state  out  PW  current page; PW = max(1, clog2(NUM_PAGES))
- menu_counter  out  IW  current item; IW = max(1, clog2(NUM_ITEMS))
- x_pointer  out  11  pointer x
- y_pointer  out  11  pointer y
- pointer_visible  out  1  blink phase; 1 = draw the pointer
- select_valid  out  1  one-cycle pulse on a final selection
- select_page  out  PW  page of the last selection
- select_item  out  IW  item of the last selection

Behaviour:
- Key codes:
  - 1 = UP, 2 = DOWN, 3 = ENTER, 4 = ESC.
  - All other nonzero codes are ignored, but they still reset the idle counter.
- Reset values (asynchronous):
  - menu_state = 0, menu_counter = 0.
  - x_pointer = X_BASE, y_pointer = Y_BASE.
  - pointer_visible = 1, select_valid = 0.
  - select_page = 0, select_item = 0.
  - Blink and idle counters = 0.
- Page/item state machine (all transitions on the clk edge that samples the event):
  - UP: item − 1. At item 0: goes to NUM_ITEMS−1 if WRAP=1, else stays at 0.
  - DOWN: item + 1. At NUM_ITEMS−1: goes to 0 if WRAP=1, else stays.
  - ENTER on page 0, item i, with i+1 < NUM_PAGES: page ← i+1, item ← 0. No select pulse.
  - ENTER on page 0, item i, with i+1 ≥ NUM_PAGES: select_valid = 1 for one cycle; select_page/select_item ← 0/i.
  - ENTER on page p > 0: select_valid = 1 for one cycle; select_page ← p, select_item ← current item. Page and item are unchanged.
  - ESC on page p > 0: page ← 0, item ← p−1, so the cursor returns to the entry that opened page p.
  - ESC on page 0: no effect.
- Latency:
  - Event sampled at edge n → menu_state/menu_counter/select_valid valid after edge n.
  - x_pointer/y_pointer updated one edge later (n+1).
  - y_pointer = Y_BASE + item·Y_STEP, computed in 11-bit arithmetic (truncating); x_pointer = X_BASE.
- select_page/select_item hold their value until the next selection.
- Blink:
  - A counter counts 0…BLINK_CYCLES−1; pointer_visible toggles on wrap.
  - Any valid UP/DOWN/ENTER/ESC event forces pointer_visible = 1 and clears the counter, so the pointer is always visible right after movement.
- Idle timeout:
  - The counter increments every cycle with no event and clears on any nonzero keyboard_in.
  - On reaching TIMEOUT_CYCLES−1: page ← 0, item ← 0, counter cleared, no select pulse.
  - If an event and the timeout expire on the same cycle, the event wins and the counter clears.
- Reset asserted mid-operation returns everything to reset values immediately. A select pulse in flight is cancelled.
- Counter widths are sized from the parameters; no counter overflows for any legal parameter value.

Test Plan (NUM_PAGES=3, NUM_ITEMS=3, X_BASE=300, Y_BASE=200, Y_STEP=100, BLINK_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset, then idle 2 cycles → state 0/0, x=300, y=200, visible=1, select_valid=0.
- WRAP=1: DOWN, DOWN, DOWN → item 1, 2, 0; y = 300, 400, 200, each one cycle after its item change. UP from item 0 → item 2, y=400. With WRAP=0: UP at 0 stays 0; DOWN at 2 stays 2.
- From 0/1, ENTER → page 2, item 0. DOWN → item 1. ENTER → one-cycle select_valid with select_page=2, select_item=1; page stays 2. ESC → page 0, item 1.
- From 0/2, ENTER (3 ≥ NUM_PAGES) → select_valid pulse, select_page/select_item = 0/2, page unchanged.
- No keys → visible toggles every 4 cycles; after 20 idle cycles on page 1, item 2 → state 0/0. An event on cycle 19 prevents the return. Any event forces visible=1.
- Assert rst while on page 2 during a select pulse → all outputs return to reset values immediately and select_valid drops.
